// File: rtl/io_int_peripheral_if.sv
// rtl/io_int_peripheral_if.sv - processor-side pin bundle of the I/O and interrupt peripheral
//
// Purpose: groups the four pins that face the processor core.
//   int_flag : interrupt request towards the processor
//   ack      : interrupt acknowledge from the processor (pulse or level)
//   portIn   : value presented on the processor input port
//   portOut  : processor output port, observed by the peripheral
// Modports:
//   slave  : the peripheral (drives int_flag/portIn, observes ack/portOut)
//   master : the processor side (or a bench standing in for it)
interface io_int_peripheral_if #(
    parameter int WIDTH = 16
);
    logic             int_flag;
    logic             ack;
    logic [WIDTH-1:0] portIn;
    logic [WIDTH-1:0] portOut;

    modport slave (
        output int_flag,
        output portIn,
        input  ack,
        input  portOut
    );

    modport master (
        input  int_flag,
        input  portIn,
        output ack,
        output portOut
    );
endinterface

// File: rtl/io_int_peripheral.sv
// rtl/io_int_peripheral.sv - interrupt generator, input-port driver and output-port capture FIFO
//
// Purpose: external-side counterpart to a processor's I/O and interrupt pins.
//   - Queues interrupt requests, raises int_flag, waits for ack (with timeout),
//     then enforces a holdoff window before the next interrupt.
//   - Drives portIn from in_data on in_load.
//   - Logs every change of portOut into a FIFO drained by the environment.
// Ports:
//   clk, reset          : clock (rising edge), asynchronous active-low reset
//   proc (slave)        : int_flag, ack, portIn, portOut
//   irq_req             : one interrupt request per cycle it is high
//   in_load, in_data    : load the next portIn value
//   out_pop             : pop the capture FIFO head
//   out_data, out_valid : FIFO head and not-empty flag
//   out_count           : FIFO occupancy
//   irq_pending         : queued interrupt requests (saturating)
//   busy                : interrupt FSM not idle
//   timeout_err         : sticky, ack never arrived
//   overflow_err        : sticky, capture dropped on full FIFO
//   err_clr             : clears both sticky errors (a same-cycle set wins)
module io_int_peripheral #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 64,
    parameter int HOLDOFF     = 2,
    parameter int MAX_PENDING = 15,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1,
    localparam int PW = $clog2(MAX_PENDING + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    io_int_peripheral_if.slave   proc,
    input  logic                 irq_req,
    input  logic                 in_load,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 out_pop,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic [CW-1:0]        out_count,
    output logic [PW-1:0]        irq_pending,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 overflow_err,
    input  logic                 err_clr
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int HW = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    wait_q, wait_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             flag_q, flag_d;
    logic [PW-1:0]    pend_q, pend_d;
    logic             tmo_q, tmo_d;
    logic             launch, tmo_set;

    logic [WIDTH-1:0] port_in_q, port_in_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             changed, full, pop_ok, push_ok, drop;

    // Interrupt FSM: next state and outputs.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        hold_d  = hold_q;
        flag_d  = flag_q;
        launch  = 1'b0;
        tmo_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A fresh request launches straight away without ever being counted.
                if (pend_q != '0 || irq_req) begin
                    launch  = 1'b1;
                    flag_d  = 1'b1;
                    wait_d  = '0;
                    state_d = S_ASSERT;
                end
            end
            S_ASSERT: begin
                // ack is checked first so that ack in the last waiting cycle wins.
                if (proc.ack) begin
                    flag_d  = 1'b0;
                    hold_d  = '0;
                    state_d = S_HOLD;
                end else if (wait_q == TW'(ACK_TIMEOUT - 1)) begin
                    tmo_set = 1'b1;
                    flag_d  = 1'b0;
                    hold_d  = '0;
                    state_d = S_HOLD;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (hold_q == HW'(HOLDOFF - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                flag_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Pending counter: a request and a launch in the same cycle cancel out.
    // A launch with an empty counter always coincides with irq_req, so no underflow.
    always_comb begin
        pend_d = pend_q;
        if (irq_req && !launch && pend_q != PW'(MAX_PENDING)) begin
            pend_d = pend_q + 1'b1;
        end else if (!irq_req && launch) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // Capture FIFO: a pop in the same cycle frees the slot for a push into a full FIFO.
    always_comb begin
        changed = proc.portOut != last_q;
        full    = count_q == CW'(DEPTH);
        pop_ok  = out_pop && count_q != '0;
        push_ok = changed && (!full || pop_ok);
        drop    = changed && full && !pop_ok;
        last_d  = changed ? proc.portOut : last_q;
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        port_in_d = in_load ? in_data : port_in_q;
        tmo_d     = tmo_set | (tmo_q & ~err_clr);
        ovf_d     = drop | (ovf_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            hold_q    <= '0;
            flag_q    <= 1'b0;
            pend_q    <= '0;
            tmo_q     <= 1'b0;
            port_in_q <= '0;
            last_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            hold_q    <= hold_d;
            flag_q    <= flag_d;
            pend_q    <= pend_d;
            tmo_q     <= tmo_d;
            port_in_q <= port_in_d;
            last_q    <= last_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= proc.portOut;
        end
    end

    assign proc.int_flag = flag_q;
    assign proc.portIn   = port_in_q;
    assign out_valid     = count_q != '0;
    assign out_data      = out_valid ? mem_q[rd_q] : '0;
    assign out_count     = count_q;
    assign irq_pending   = pend_q;
    assign busy          = state_q != S_IDLE;
    assign timeout_err   = tmo_q;
    assign overflow_err  = ovf_q;
endmodule

// File: tb/tb_io_int_peripheral.sv
// tb/tb_io_int_peripheral.sv - self-checking bench for io_int_peripheral
module tb_io_int_peripheral;
    localparam int WIDTH       = 16;
    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 64;
    localparam int HOLDOFF     = 2;
    localparam int MAX_PENDING = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq_req, in_load, out_pop, err_clr;
    logic [15:0] in_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic [3:0]  out_count;
    logic [3:0]  irq_pending;
    logic        busy, timeout_err, overflow_err;

    io_int_peripheral_if #(.WIDTH(WIDTH)) bus ();

    io_int_peripheral #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT),
        .HOLDOFF(HOLDOFF), .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk(clk), .reset(reset), .proc(bus),
        .irq_req(irq_req), .in_load(in_load), .in_data(in_data),
        .out_pop(out_pop), .out_data(out_data), .out_valid(out_valid),
        .out_count(out_count), .irq_pending(irq_pending), .busy(busy),
        .timeout_err(timeout_err), .overflow_err(overflow_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        irq_req = 0; in_load = 0; in_data = 0; out_pop = 0; err_clr = 0;
        bus.ack = 0; bus.portOut = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic irq, ack, ld, pop;
        logic [15:0] din, pout;
        logic flag, bsy;
        logic [3:0] pend, cnt;
        logic [15:0] pin, odata;
    } vec_t;

    function automatic vec_t mk(input int irq, input int ack, input int ld, input int din,
                                input int pout, input int pop, input int flag, input int bsy,
                                input int pend, input int pin, input int cnt, input int odata);
        vec_t v;
        v.irq = irq[0]; v.ack = ack[0]; v.ld = ld[0]; v.din = din[15:0];
        v.pout = pout[15:0]; v.pop = pop[0]; v.flag = flag[0]; v.bsy = bsy[0];
        v.pend = pend[3:0]; v.pin = pin[15:0]; v.cnt = cnt[3:0]; v.odata = odata[15:0];
        return v;
    endfunction

    function automatic logic [63:0] pack(input logic f, input logic b, input logic [3:0] p,
                                         input logic [15:0] pin, input logic [3:0] c,
                                         input logic v, input logic [15:0] od,
                                         input logic t, input logic o);
        return 64'({f, b, p, pin, c, v, od, t, o});
    endfunction

    // Reference model state
    logic [15:0] mq[$];
    logic [15:0] m_last, m_pin;
    int          m_pend, m_since, m_hold;
    bit          m_flag, m_tmo, m_ovf;

    vec_t tbl[13];

    initial begin
        int peak, pulses, low_run, min_gap, hi;
        bit prev_flag;
        logic [63:0] exp_v, act_v;

        reset = 1'b1;
        #2;
        do_reset();
        reset = 1'b0;
        #1;
        chk("rst_flag", 64'(bus.int_flag), 0);
        chk("rst_outs", pack(busy, out_valid, irq_pending, bus.portIn, out_count, 1'b0,
                             out_data, timeout_err, overflow_err), 0);
        reset = 1'b1;

        // ---------------- table-driven vectors ----------------
        //            irq ack ld din     pout pop | flag busy pend pin     cnt odata
        tbl[0]  = mk(1, 0, 1, 'h1234, 0, 0,   1, 1, 0, 'h1234, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0,      5, 0,   1, 1, 0, 'h1234, 1, 5);
        tbl[2]  = mk(1, 0, 0, 0,      5, 0,   1, 1, 1, 'h1234, 1, 5);
        tbl[3]  = mk(0, 0, 0, 0,      7, 0,   1, 1, 1, 'h1234, 2, 5);
        tbl[4]  = mk(0, 1, 0, 0,      7, 0,   0, 1, 1, 'h1234, 2, 5);
        tbl[5]  = mk(0, 1, 0, 0,      7, 0,   0, 1, 1, 'h1234, 2, 5);
        tbl[6]  = mk(0, 0, 0, 0,      7, 0,   0, 0, 1, 'h1234, 2, 5);
        tbl[7]  = mk(0, 0, 0, 0,      7, 0,   1, 1, 0, 'h1234, 2, 5);
        tbl[8]  = mk(0, 0, 1, 'h00AB, 7, 1,   1, 1, 0, 'h00AB, 1, 7);
        tbl[9]  = mk(0, 1, 0, 0,      7, 1,   0, 1, 0, 'h00AB, 0, 0);
        tbl[10] = mk(0, 0, 0, 0,      7, 1,   0, 1, 0, 'h00AB, 0, 0);
        tbl[11] = mk(0, 0, 0, 0,      7, 0,   0, 0, 0, 'h00AB, 0, 0);
        tbl[12] = mk(0, 1, 0, 0,      7, 0,   0, 0, 0, 'h00AB, 0, 0);
        do_reset();
        for (int i = 0; i < 13; i++) begin
            irq_req = tbl[i].irq; bus.ack = tbl[i].ack; in_load = tbl[i].ld;
            in_data = tbl[i].din; bus.portOut = tbl[i].pout; out_pop = tbl[i].pop;
            step();
            chk($sformatf("vec%0d_flag", i), 64'(bus.int_flag), 64'(tbl[i].flag));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
            chk($sformatf("vec%0d_pend", i), 64'(irq_pending), 64'(tbl[i].pend));
            chk($sformatf("vec%0d_portin", i), 64'(bus.portIn), 64'(tbl[i].pin));
            chk($sformatf("vec%0d_count", i), 64'(out_count), 64'(tbl[i].cnt));
            chk($sformatf("vec%0d_odata", i), 64'(out_data), 64'(tbl[i].odata));
        end

        // ---------------- back-to-back requests ----------------
        do_reset();
        peak = 0; pulses = 0; low_run = 0; min_gap = 1000; hi = 0; prev_flag = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            hi = bus.int_flag ? hi + 1 : 0;
            irq_req = (cyc < 3);
            bus.ack = bus.int_flag && hi == 2;
            step();
            if (int'(irq_pending) > peak) peak = int'(irq_pending);
            if (bus.int_flag && !prev_flag) begin
                pulses++;
                if (pulses > 1 && low_run < min_gap) min_gap = low_run;
            end
            low_run = bus.int_flag ? 0 : low_run + 1;
            prev_flag = bus.int_flag;
        end
        bus.ack = 0;
        chk("b2b_peak_pending", 64'(peak), 2);
        chk("b2b_pulses", 64'(pulses), 3);
        chk("b2b_gap_ge_holdoff", 64'(min_gap >= HOLDOFF), 1);

        // ---------------- timeout ----------------
        do_reset();
        irq_req = 1; step(); irq_req = 0;
        chk("to_flag_c1", 64'(bus.int_flag), 1);
        for (int i = 1; i < ACK_TIMEOUT; i++) step();
        chk("to_flag_last", 64'(bus.int_flag), 1);
        chk("to_err_before", 64'(timeout_err), 0);
        err_clr = 1; step(); err_clr = 0;
        chk("to_flag_drop", 64'(bus.int_flag), 0);
        chk("to_err_set_wins", 64'(timeout_err), 1);
        err_clr = 1; step(); err_clr = 0;
        chk("to_err_clr", 64'(timeout_err), 0);
        step();
        chk("to_idle", 64'(busy), 0);
        irq_req = 1; step(); irq_req = 0;
        for (int i = 1; i < ACK_TIMEOUT; i++) step();
        bus.ack = 1; step(); bus.ack = 0;
        chk("to_ack_wins_flag", 64'(bus.int_flag), 0);
        chk("to_ack_wins_err", 64'(timeout_err), 0);

        // ---------------- pending saturation ----------------
        do_reset();
        irq_req = 1;
        for (int i = 0; i < 20; i++) step();
        irq_req = 0;
        chk("pend_saturate", 64'(irq_pending), MAX_PENDING);

        // ---------------- capture and overflow ----------------
        do_reset();
        for (int v = 1; v <= 10; v++) begin bus.portOut = 16'(v); step(); end
        chk("ovf_count", 64'(out_count), DEPTH);
        chk("ovf_err", 64'(overflow_err), 1);
        for (int v = 1; v <= DEPTH; v++) begin
            chk($sformatf("ovf_pop%0d", v), 64'(out_data), 64'(v));
            out_pop = 1; step();
        end
        out_pop = 0;
        chk("ovf_drained", 64'(out_count), 0);
        repeat (3) step();
        chk("same_value_no_push", 64'(out_count), 0);

        // ---------------- full FIFO push+pop ----------------
        do_reset();
        for (int v = 1; v <= DEPTH; v++) begin bus.portOut = 16'(v); step(); end
        bus.portOut = 9; out_pop = 1; step(); out_pop = 0;
        chk("pp_count", 64'(out_count), DEPTH);
        chk("pp_no_ovf", 64'(overflow_err), 0);
        for (int v = 2; v <= 9; v++) begin
            chk($sformatf("pp_pop%0d", v), 64'(out_data), 64'(v));
            out_pop = 1; step();
        end
        out_pop = 0;

        // ---------------- reset mid-ASSERT ----------------
        do_reset();
        in_load = 1; in_data = 16'h55AA; step(); in_load = 0;
        for (int i = 0; i < 5; i++) begin
            irq_req = (i < 4); bus.portOut = 16'(i + 1); step();
        end
        irq_req = 0;
        chk("mid_pend", 64'(irq_pending), 3);
        chk("mid_count", 64'(out_count), 5);
        chk("mid_flag", 64'(bus.int_flag), 1);
        #1 reset = 1'b0;
        #1;
        chk("arst_flag", 64'(bus.int_flag), 0);
        chk("arst_pend", 64'(irq_pending), 0);
        chk("arst_count", 64'(out_count), 0);
        chk("arst_portin", 64'(bus.portIn), 0);
        chk("arst_busy", 64'(busy), 0);

        // ---------------- randomized vs reference model ----------------
        do_reset();
        mq.delete(); m_last = 0; m_pin = 0; m_pend = 0; m_since = 0; m_hold = 0;
        m_flag = 0; m_tmo = 0; m_ovf = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit idle, launch, tset, oset, popk;
            irq_req     = ($urandom_range(0, 7) == 0);
            bus.ack     = ($urandom_range(0, 15) == 0);
            in_load     = ($urandom_range(0, 3) == 0);
            in_data     = 16'($urandom);
            out_pop     = ($urandom_range(0, 2) == 0);
            err_clr     = ($urandom_range(0, 31) == 0);
            bus.portOut = 16'($urandom_range(0, 3));

            idle   = !m_flag && m_hold == 0;
            launch = idle && (m_pend > 0 || irq_req);
            tset   = 0;
            if (m_flag) begin
                m_since++;
                if (bus.ack) begin m_flag = 0; m_hold = HOLDOFF; end
                else if (m_since == ACK_TIMEOUT) begin tset = 1; m_flag = 0; m_hold = HOLDOFF; end
            end else if (m_hold > 0) begin
                m_hold--;
            end else if (launch) begin
                m_flag = 1; m_since = 0;
            end
            m_pend = m_pend + int'(irq_req) - int'(launch);
            if (m_pend > MAX_PENDING) m_pend = MAX_PENDING;
            m_tmo = tset ? 1'b1 : (err_clr ? 1'b0 : m_tmo);

            popk = out_pop && mq.size() > 0;
            oset = 0;
            if (popk) void'(mq.pop_front());
            if (bus.portOut != m_last) begin
                m_last = bus.portOut;
                if (mq.size() < DEPTH) mq.push_back(bus.portOut);
                else oset = 1;
            end
            m_ovf = oset ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
            if (in_load) m_pin = in_data;

            step();
            exp_v = pack(m_flag, m_flag || m_hold > 0, 4'(m_pend), m_pin, 4'(mq.size()),
                         mq.size() > 0, (mq.size() > 0) ? mq[0] : 16'h0, m_tmo, m_ovf);
            act_v = pack(bus.int_flag, busy, irq_pending, bus.portIn, out_count,
                         out_valid, out_data, timeout_err, overflow_err);
            chk($sformatf("rand_c%0d", cyc), act_v, exp_v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/io_int_peripheral.md
Name: io_int_peripheral

Overview:
- External-side counterpart to the processor's I/O and interrupt pins.
- Drives `portIn` and `int_flag`, receives `ack`, and captures `portOut` writes.
- Generates interrupt requests with an ack handshake, a timeout, a holdoff window and a pending-request counter.
- Logs every change on `portOut` into a FIFO that the environment drains.
- Sits outside the processor core; used in system integration and processor-level benches.

Parameters:
- WIDTH, 16, port data width.
- DEPTH, 8, portOut capture FIFO depth (power of two, ≥2).
- ACK_TIMEOUT, 64, cycles to wait for `ack` after raising `int_flag`.
- HOLDOFF, 2, idle cycles forced after each interrupt completes (≥1).
- MAX_PENDING, 15, saturation value of the pending-request counter.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous active-low reset.
- int_flag, output, 1: interrupt request to the processor.
- ack, input, 1: interrupt acknowledge from the processor; a pulse or a level.
- portIn, output, WIDTH: value presented to the processor input port.
- portOut, input, WIDTH: processor output port.
- irq_req, input, 1: environment request for one interrupt, sampled per cycle.
- in_load, input, 1: load `in_data` into `portIn`.
- in_data, input, WIDTH: next input port value.
- out_pop, input, 1: pop the capture FIFO head.
- out_data, output, WIDTH: capture FIFO head (valid when `out_valid`=1).
- out_valid, output, 1: FIFO not empty.
- out_count, output, clog2(DEPTH)+1: FIFO occupancy.
- irq_pending, output, clog2(MAX_PENDING+1): queued interrupt requests.
- busy, output, 1: interrupt FSM not in IDLE.
- timeout_err, output, 1: sticky; no ack within ACK_TIMEOUT.
- overflow_err, output, 1: sticky; capture dropped while FIFO full.
- err_clr, input, 1: synchronous clear of both sticky errors.

Behaviour:

Reset (reset=0, asynchronous):
- All outputs 0, FSM in IDLE, FIFO empty, last_out register = 0, counters = 0.
- Reset mid-handshake drops `int_flag` immediately and discards pending requests and FIFO contents.

Pending counter:
- Each cycle `irq_req`=1 adds 1, saturating at MAX_PENDING.
- Each FSM launch (IDLE→ASSERT) subtracts 1.
- Both in the same cycle leaves the counter unchanged.

Interrupt FSM states: IDLE, ASSERT, HOLD.
- IDLE:
  - If `irq_pending`>0, or `irq_req`=1 this cycle, go to ASSERT next cycle.
  - A request arriving in IDLE with an empty counter launches directly and is never counted.
  - The `int_flag` register is set on that edge, so `int_flag`=1 one cycle after `irq_req`.
- ASSERT:
  - `int_flag`=1 and the wait counter increments each cycle.
  - `ack`=1 sampled: clear `int_flag` at the next edge, go to HOLD.
  - Wait counter reaches ACK_TIMEOUT without `ack`: set `timeout_err`, clear `int_flag`, go to HOLD.
  - `ack` and timeout in the same cycle: `ack` wins, `timeout_err` is not set.
- HOLD:
  - `int_flag`=0 for exactly HOLDOFF cycles, then IDLE.
  - `ack` is ignored in HOLD and IDLE (a level ack does not retrigger anything).
- `busy`=1 in ASSERT and HOLD.

Input port:
- `in_load`=1: `portIn` <= `in_data` at the edge; otherwise `portIn` holds.

Output capture:
- Each cycle, compare `portOut` with last_out.
- If different: last_out <= `portOut` and push `portOut` into the FIFO.
- Push when full: word dropped, `overflow_err` set, last_out still updated.

FIFO pop and simultaneous events:
- `out_pop` with `out_valid`=1 advances the head; `out_pop` when empty is ignored.
- Push and pop in the same cycle: occupancy unchanged, and a full FIFO accepts the push without overflow.
- Pointers wrap modulo DEPTH.
- `out_data` is combinational from the head entry.

Errors:
- `err_clr` clears both sticky errors.
- A set event and `err_clr` in the same cycle: set wins.

Test Plan:
- Single interrupt: pulse `irq_req` at cycle 0; `ack` pulse at cycle 4 → `int_flag` high cycles 1–4, low from 5; `busy` low at cycle 7 (HOLDOFF=2).
- Back-to-back requests: `irq_req` for 3 consecutive cycles while busy; ack each after 2 cycles → `irq_pending` peaks at 2; three separate `int_flag` pulses separated by ≥2 low cycles.
- Timeout: raise a request, never ack → `int_flag` drops after 64 cycles, `timeout_err`=1; `err_clr` → 0; `ack` in the timeout cycle → `timeout_err` stays 0.
- Capture and overflow: drive `portOut` 1,2,…,10 on successive cycles, no pop → `out_count`=8, `overflow_err`=1, pops return 1..8; repeated same value → no push.
- Full FIFO with simultaneous push and pop: occupancy stays 8, no overflow, order preserved.
- Reset mid-ASSERT with 3 pending and 5 FIFO words: `int_flag`, `irq_pending`, `out_count`, `portIn` all 0 immediately, before the next clock edge.
